// File: rtl/layer2_pkg.sv
// Shared types for the layer-2 weight fetch path: ROM geometry, beat payload and FSM states.
package layer2_pkg;

  localparam int unsigned L2_NUM_BANKS        = 16;
  localparam int unsigned L2_WEIGHTS_PER_BANK = 150;
  localparam int unsigned L2_BANK_W           = 4;
  localparam int unsigned L2_ADDR_W           = 8;
  localparam int unsigned L2_WEIGHT_W         = 8;

  typedef logic signed [L2_WEIGHT_W-1:0] weight_t;
  typedef logic [L2_BANK_W-1:0]          bank_id_t;
  typedef logic [L2_ADDR_W-1:0]          waddr_t;

  typedef struct packed {
    weight_t  data;
    bank_id_t bank;
    waddr_t   idx;
    logic     last;
  } weight_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/weight_beat_fifo.sv
// Small synchronous FIFO of weight beats; simultaneous push and pop is legal even when full.
module weight_beat_fifo
  import layer2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  weight_beat_t                 push_data,
  input  logic                         pop,
  output weight_beat_t                 pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  weight_beat_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/layer2_weight_fetcher.sv
// Walks ROM banks ch_lo..ch_hi, absorbs the 1-cycle ROM latency and streams weights
// through a credit-guarded FIFO so no ROM word is dropped under backpressure.
module layer2_weight_fetcher
  import layer2_pkg::*;
#(
  parameter int unsigned NUM_BANKS        = L2_NUM_BANKS,
  parameter int unsigned WEIGHTS_PER_BANK = L2_WEIGHTS_PER_BANK,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        ch_lo,
  input  logic [3:0]        ch_hi,
  output logic [3:0]        rom_bank_id,
  output logic [7:0]        rom_addr,
  input  logic signed [7:0] rom_weight,
  output logic              w_valid,
  input  logic              w_ready,
  output logic signed [7:0] w_data,
  output logic [3:0]        w_bank,
  output logic [7:0]        w_idx,
  output logic              w_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam waddr_t      LAST_ADDR = waddr_t'(WEIGHTS_PER_BANK - 1);
  localparam bank_id_t    LAST_BANK = bank_id_t'(NUM_BANKS - 1);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  bank_id_t         bank_q;
  bank_id_t         hi_q;
  waddr_t           addr_q;
  bank_id_t         tag_bank_q;
  waddr_t           tag_idx_q;
  logic             tag_last_q;
  logic             inflight_q;
  logic             busy_q;
  logic             done_q;

  logic             issue_c;
  logic             load_c;
  logic             last_rd_c;
  logic             credit_c;
  logic             drain_exit_c;
  logic             pop_c;

  weight_beat_t     push_beat;
  weight_beat_t     head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  assign pop_c     = !fifo_empty && w_ready;
  assign last_rd_c = (bank_q == hi_q) && (addr_q == LAST_ADDR);
  // A read may only go out if the FIFO can still hold it alongside the one already in flight.
  assign credit_c  = !fifo_full &&
                     ((32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH);
  // Look ahead by one pop so done follows the final handshake directly.
  assign drain_exit_c = !inflight_q &&
                        ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop_c));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (ch_lo <= ch_hi) begin
            state_d = FETCH;
            load_c  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        issue_c = credit_c;
        if (credit_c && last_rd_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_exit_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address counters, read tag pipeline and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q     <= '0;
      addr_q     <= '0;
      hi_q       <= '0;
      tag_bank_q <= '0;
      tag_idx_q  <= '0;
      tag_last_q <= 1'b0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= issue_c;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
      if (load_c) begin
        bank_q <= ch_lo;
        addr_q <= '0;
        hi_q   <= ch_hi;
      end else if (issue_c && !last_rd_c) begin
        if (addr_q == LAST_ADDR) begin
          addr_q <= '0;
          bank_q <= (bank_q == LAST_BANK) ? '0 : bank_q + bank_id_t'(1);
        end else begin
          addr_q <= addr_q + waddr_t'(1);
        end
      end
      if (issue_c) begin
        tag_bank_q <= bank_q;
        tag_idx_q  <= addr_q;
        tag_last_q <= (addr_q == LAST_ADDR);
      end
    end
  end

  always_comb begin
    push_beat      = '0;
    push_beat.data = rom_weight;
    push_beat.bank = tag_bank_q;
    push_beat.idx  = tag_idx_q;
    push_beat.last = tag_last_q;
  end

  weight_beat_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (push_beat),
    .pop       (pop_c),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rom_bank_id = bank_q;
  assign rom_addr    = addr_q;
  assign w_valid     = !fifo_empty;
  assign w_data      = head.data;
  assign w_bank      = head.bank;
  assign w_idx       = head.idx;
  assign w_last      = head.last;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_layer2_weight_fetcher.sv
// Directed bench for layer2_weight_fetcher: ROM model, table of channel ranges, and
// hand-written reset / ignored-start sequences.
module tb_layer2_weight_fetcher;
  import layer2_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [3:0]        ch_lo;
  logic [3:0]        ch_hi;
  logic [3:0]        rom_bank_id;
  logic [7:0]        rom_addr;
  logic signed [7:0] rom_weight;
  logic              w_valid;
  logic              w_ready;
  logic signed [7:0] w_data;
  logic [3:0]        w_bank;
  logic [7:0]        w_idx;
  logic              w_last;
  logic              busy;
  logic              done;

  int n_tests;
  int n_fail;

  layer2_weight_fetcher dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ch_lo       (ch_lo),
    .ch_hi       (ch_hi),
    .rom_bank_id (rom_bank_id),
    .rom_addr    (rom_addr),
    .rom_weight  (rom_weight),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .w_bank      (w_bank),
    .w_idx       (w_idx),
    .w_last      (w_last),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic weight_t rom_model(input bank_id_t b, input waddr_t i);
    int unsigned v;
    v = (32'(b) * 29 + 32'(i) * 7 + 3) ^ (32'(i) >> 2);
    return weight_t'(v[7:0]);
  endfunction

  // Registered-read ROM: data appears the cycle after the address is presented.
  always @(posedge clk) rom_weight <= rom_model(rom_bank_id, rom_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({w_valid, done, busy, rom_bank_id, rom_addr, w_data, w_bank, w_idx, w_last});
  endfunction

  typedef struct {
    bank_id_t lo;
    bank_id_t hi;
    int       mode;       // 0: w_ready held high, 1: w_ready low ~30% of cycles
    int       exp_beats;
    int       exp_lasts;
  } vec_t;

  // inj_cyc >= 0 pulses a stray start (ch 5..5); rst_after >= 0 resets after that many beats.
  task automatic run_req(input bank_id_t lo, input bank_id_t hi, input int mode,
                         input int exp_beats, input int exp_lasts,
                         input int inj_cyc, input int rst_after, input string tag);
    int          beats     = 0;
    int          lasts     = 0;
    int          dones     = 0;
    int          done_cyc  = -1;
    int          first_v   = -1;
    int          last_hs   = -1;
    int          bubbles   = 0;
    int          max_cnt   = 0;
    int          valid_cnt = 0;
    logic        stalled   = 1'b0;
    logic        finished  = 1'b0;
    logic [20:0] held      = '0;
    logic [20:0] cur;
    bank_id_t    eb        = lo;
    waddr_t      ei        = '0;

    @(negedge clk);
    start = 1'b1;
    ch_lo = lo;
    ch_hi = hi;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
      start = (cyc == inj_cyc);
      if (cyc == inj_cyc) begin
        ch_lo = 4'd5;
        ch_hi = 4'd5;
      end
      if (rst_after >= 0 && beats == rst_after) begin
        rst_n   = 1'b0;
        w_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_outputs_after_reset"}, out_vec(), 64'd0);
        chk({tag, "_state_after_reset"}, 64'(dut.state_q), 64'(IDLE));
        chk({tag, "_no_done_before_reset"}, 64'(dones), 64'd0);
        rst_n = 1'b1;
        return;
      end
      if (32'(dut.u_fifo.count) > max_cnt) max_cnt = 32'(dut.u_fifo.count);
      cur = {w_data, w_bank, w_idx, w_last};
      if (w_valid) begin
        valid_cnt++;
        if (first_v < 0) first_v = cyc;
        if (stalled) chk({tag, "_hold"}, 64'(cur), 64'(held));
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk({tag, "_busy_after_done"}, 64'({busy, done}), 64'd0);
        finished = 1'b1;
      end
      w_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) >= 30);
      if (w_valid && w_ready) begin
        chk({tag, "_beat"}, 64'(cur),
            64'({rom_model(eb, ei), eb, ei, (ei == 8'd149)}));
        beats++;
        if (w_last) lasts++;
        if (mode == 0 && last_hs >= 0 && cyc != last_hs + 1) bubbles++;
        last_hs = cyc;
        if (ei == 8'd149) begin
          ei = '0;
          eb = bank_id_t'(eb + 4'd1);
        end else begin
          ei = waddr_t'(ei + 8'd1);
        end
      end
      stalled = w_valid && !w_ready;
      held    = cur;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_completed"}, 64'(finished), 64'd1);
    chk({tag, "_beats"}, 64'(beats), 64'(exp_beats));
    chk({tag, "_lasts"}, 64'(lasts), 64'(exp_lasts));
    chk({tag, "_done_pulses"}, 64'(dones), 64'd1);
    chk({tag, "_fifo_bound"}, 64'(max_cnt > 4), 64'd0);
    if (exp_beats > 0) begin
      // start sampled at cycle -1's edge: reads issue at 0, data at 1, beat visible at 2
      chk({tag, "_first_valid"}, 64'(first_v), 64'd2);
      chk({tag, "_done_gap"}, 64'(done_cyc - last_hs), 64'd1);
    end else begin
      chk({tag, "_no_valid"}, 64'(valid_cnt), 64'd0);
      chk({tag, "_done_cycle"}, 64'(done_cyc), 64'd0);
    end
    if (mode == 0) chk({tag, "_bubbles"}, 64'(bubbles), 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int quiet;
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{4'd0,  4'd15, 0, 2400, 16};
    vecs[1] = '{4'd7,  4'd7,  0, 150,  1};
    vecs[2] = '{4'd3,  4'd4,  1, 300,  2};
    vecs[3] = '{4'd9,  4'd2,  0, 0,    0};
    vecs[4] = '{4'd14, 4'd15, 1, 300,  2};

    rst_n   = 1'b0;
    start   = 1'b0;
    ch_lo   = '0;
    ch_hi   = '0;
    w_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec(), 64'd0);
    chk("reset_state", 64'(dut.state_q), 64'(IDLE));
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_req(vecs[i].lo, vecs[i].hi, vecs[i].mode, vecs[i].exp_beats,
              vecs[i].exp_lasts, -1, -1, $sformatf("vec%0d", i));
    end

    run_req(4'd2, 4'd3, 0, 0, 0, -1, 50, "reset_mid");
    run_req(4'd0, 4'd0, 0, 150, 1, -1, -1, "after_reset");

    run_req(4'd1, 4'd1, 0, 150, 1, 5, -1, "ignored_start");
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || w_valid || busy) quiet++;
    end
    chk("ignored_start_quiet", 64'(quiet), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
